noc_inject_arbiter: RTL and testbench
=====================================

// Module: noc_inject_arbiter
// PURPOSE
//  Shares one NoC local injection port among NUM_REQ packet sources (test nodes, DMA, AXI bridge).
//  Arbitrates per packet, round-robin, wormhole style: the grant locks from header flit to tail flit.
//  Sits between the local sources and the router local input port. Counts packets sent, flags orphan flits.
// PARAMETERS
//  NUM_REQ   4                  number of requesters, 2..8
//  IDX_W     3                  grant index width; requires 2**IDX_W >= NUM_REQ
//  DATA_W    `Noc_Data_Width    flit width
// PORTS
//  noc_clk        in   1               clock
//  noc_rst        in   1               synchronous reset, active-high
//  req_valid      in   NUM_REQ         per-requester flit valid
//  req_ready      out  NUM_REQ         per-requester flit accepted
//  req_flit       in   NUM_REQ*DATA_W  flits; requester i occupies [i*DATA_W +: DATA_W]
//  req_is_header  in   NUM_REQ         flit is packet header
//  req_is_tail    in   NUM_REQ         flit is packet tail
//  out_valid      out  1               flit valid to router
//  out_ready      in   1               router accepts flit
//  out_flit       out  DATA_W          selected flit
//  out_is_header  out  1               selected header flag
//  out_is_tail    out  1               selected tail flag
//  grant_id       out  IDX_W           current/last granted requester
//  busy           out  1               1 while a packet is locked
//  pkt_sent       out  16              tail transfers completed, wraps 0xFFFF->0
//  err_orphan     out  NUM_REQ         sticky: requester i presented valid non-header flit while not granted
// BEHAVIOUR
//  Transfer on a port = valid & ready in the same cycle. Sources hold flit/flags stable until transfer.
//  FSM (registered): IDLE, LOCK.
//  IDLE: req_ready=0, out_valid=0, out_flit/out_is_header/out_is_tail=0.
//   Candidates = req_valid[i] & req_is_header[i]. Winner = first candidate searching from rr_ptr+1 mod NUM_REQ.
//   Any candidate -> next cycle LOCK, grant_id<=winner, rr_ptr<=winner. None -> stay IDLE.
//  LOCK (g=grant_id): out_valid=req_valid[g], out_flit/out_is_header/out_is_tail = requester g fields,
//   req_ready[g]=out_ready, all other req_ready=0. Combinational path, zero latency through the mux.
//   Transfer with out_is_tail=1 -> IDLE next cycle, pkt_sent+1. So one bubble cycle per packet.
//   Single-flit packet (header & tail both 1) legal: locks, transfers once, returns to IDLE.
//   Header flit seen again in LOCK before tail: passed through unchanged (no protocol check inside a lock).
//  Arbitration latency: header valid in IDLE -> out_valid the cycle after.
//  err_orphan[i] set when in IDLE or (LOCK and i!=g) req_valid[i]=1 & req_is_header[i]=0. Cleared only by reset.
//  Non-granted requesters are stalled, never dropped. Fairness: a requester waits at most NUM_REQ-1 packets.
//  out_ready low in LOCK: holds state, no count, grant unchanged (no timeout).
//  Reset (noc_rst=1 at posedge, any state incl. mid-packet): state=IDLE, grant_id=0, rr_ptr=NUM_REQ-1
//   (req0 wins first tie), busy=0, pkt_sent=0, err_orphan=0. A packet in flight is abandoned;
//   the downstream router is reset together with this block.
//  busy = (state==LOCK). Outputs listed for IDLE also apply during reset.
// TESTING
//  1 Reset, only req1 sends 3-flit pkt (H,D,T), out_ready=1 -> grant_id=1, 3 out transfers in order, pkt_sent=1.
//  2 All 4 headers valid from reset, 1-flit pkts re-presented -> grant order 0,1,2,3,0; pkt_sent=5 after 5 pkts.
//  3 req0 locked mid-packet, req2 raises header -> req_ready[2]=0 until req0 tail; then req2 granted next.
//  4 out_ready low 10 cycles in LOCK -> out_flit stable, req_ready[g]=0, pkt_sent unchanged; resumes on release.
//  5 req3 valid with is_header=0 while IDLE -> err_orphan=4'b1000 sticky, req3 never granted, no out_valid.
//  6 noc_rst asserted after header of req2 transferred -> next cycle busy=0, out_valid=0, pkt_sent=0; req0 wins next.

Source files
------------

// File: rtl/noc_inject_arbiter_if.sv
// Local-injection bundle between the packet sources and the router input port,
// including the arbiter's status outputs.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

interface noc_inject_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = `Noc_Data_Width
);
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DATA_W-1:0] req_flit;
  logic [NUM_REQ-1:0]        req_is_header;
  logic [NUM_REQ-1:0]        req_is_tail;
  logic                      out_valid;
  logic                      out_ready;
  logic [DATA_W-1:0]         out_flit;
  logic                      out_is_header;
  logic                      out_is_tail;
  logic [IDX_W-1:0]          grant_id;
  logic                      busy;
  logic [15:0]               pkt_sent;
  logic [NUM_REQ-1:0]        err_orphan;

  modport slave (
    input  req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    output req_ready, out_valid, out_flit, out_is_header, out_is_tail,
           grant_id, busy, pkt_sent, err_orphan
  );

  modport master (
    output req_valid, req_flit, req_is_header, req_is_tail, out_ready,
    input  req_ready, out_valid, out_flit, out_is_header, out_is_tail,
           grant_id, busy, pkt_sent, err_orphan
  );
endinterface

// File: rtl/noc_inject_arbiter.sv
// Per-packet round-robin arbiter for the NoC local injection port; the grant is
// held from header to tail and the flit path is a purely combinational mux.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif

module noc_inject_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 3,
  parameter int DATA_W  = `Noc_Data_Width
) (
  input  logic                  noc_clk,
  input  logic                  noc_rst,
  noc_inject_arbiter_if.slave   bus
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]         state_q, state_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [15:0]        pkt_q, pkt_d;
  logic [NUM_REQ-1:0] orph_q, orph_d;

  logic               lock_act;
  logic [NUM_REQ-1:0] cand, gmask;
  logic               win_vld;
  logic [IDX_W-1:0]   win_idx;
  logic               sel_valid, sel_hdr, sel_tail;
  logic [DATA_W-1:0]  sel_flit;

  // Reset forces the idle-side outputs even while the state register still says LOCK.
  assign lock_act = (state_q == S_LOCK) && !noc_rst;
  assign cand     = bus.req_valid & bus.req_is_header;

  always_comb begin
    int j;
    win_vld = 1'b0;
    win_idx = '0;
    j       = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_q) + k) % NUM_REQ;
      if (!win_vld && cand[j]) begin
        win_vld = 1'b1;
        win_idx = IDX_W'(j);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_hdr   = 1'b0;
    sel_tail  = 1'b0;
    sel_flit  = '0;
    gmask     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q == IDX_W'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_hdr   = bus.req_is_header[i];
        sel_tail  = bus.req_is_tail[i];
        sel_flit  = bus.req_flit[i*DATA_W +: DATA_W];
        gmask[i]  = (state_q == S_LOCK);
      end
    end
  end

  always_comb begin
    bus.out_valid     = lock_act && sel_valid;
    bus.out_flit      = lock_act ? sel_flit : '0;
    bus.out_is_header = lock_act && sel_hdr;
    bus.out_is_tail   = lock_act && sel_tail;
    for (int i = 0; i < NUM_REQ; i++)
      bus.req_ready[i] = lock_act && (grant_q == IDX_W'(i)) && bus.out_ready;
  end

  assign bus.grant_id   = grant_q;
  assign bus.busy       = (state_q == S_LOCK);
  assign bus.pkt_sent   = pkt_q;
  assign bus.err_orphan = orph_q;

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    pkt_d   = pkt_q;
    // A body flit from anyone but the lock owner has no packet to belong to.
    orph_d  = orph_q | (bus.req_valid & ~bus.req_is_header & ~gmask);
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          state_d = S_LOCK;
          grant_d = win_idx;
          rr_d    = win_idx;
        end
      end
      default: begin
        if (sel_valid && bus.out_ready && sel_tail) begin
          state_d = S_IDLE;
          pkt_d   = pkt_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge noc_clk) begin
    if (noc_rst) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      rr_q    <= IDX_W'(NUM_REQ - 1);
      pkt_q   <= '0;
      orph_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      pkt_q   <= pkt_d;
      orph_q  <= orph_d;
    end
  end

endmodule

// File: tb/tb_noc_inject_arbiter.sv
// Scoreboard bench for noc_inject_arbiter: packet-level reference model plus
// directed scenarios and a randomized traffic phase.
module tb_noc_inject_arbiter;
  localparam int N  = 4;
  localparam int IW = 3;
  localparam int DW = 32;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          h;
    logic          t;
  } flit_t;

  typedef struct {
    flit_t f;
    int    g;
  } exp_t;

  logic noc_clk = 1'b0;
  logic noc_rst = 1'b1;
  always #5 noc_clk = ~noc_clk;

  noc_inject_arbiter_if #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) bus ();

  noc_inject_arbiter #(.NUM_REQ(N), .IDX_W(IW), .DATA_W(DW)) dut (
    .noc_clk (noc_clk),
    .noc_rst (noc_rst),
    .bus     (bus.slave)
  );

  int tests = 0;
  int fails = 0;

  flit_t srcq[N][$];
  exp_t  exp_q[$];
  int    hdr_log[$];
  int    xfer_cnt = 0;

  // reference model: packet lock owner, last winner, counters
  bit         m_lock = 1'b0;
  int         m_g    = 0;
  int         m_rr   = N - 1;
  int         m_pkt  = 0;
  logic [N-1:0] m_orph = '0;

  bit         e_xfer = 1'b0, e_tail = 1'b0, e_arb = 1'b0;
  int         e_win  = 0;
  logic [N-1:0] e_oset = '0;

  bit         x_ov   = 1'b0;
  flit_t      x_flit = '0;
  logic [N-1:0] x_rr = '0;

  logic [N-1:0] held    = '0;
  logic [N-1:0] orph_en = '0;
  bit rst_req = 1'b1, rst_now = 1'b1, mon_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic enqueue_pkt(input int r, input int len);
    for (int k = 0; k < len; k++) begin
      flit_t f;
      f.d = $urandom;
      f.h = (k == 0);
      f.t = (k == len - 1);
      srcq[r].push_back(f);
    end
  endtask

  function automatic bit pending();
    for (int i = 0; i < N; i++) if (srcq[i].size() > 0) return 1'b1;
    return m_lock || e_arb;
  endfunction

  task automatic step(input int pv, input int pr);
    @(posedge noc_clk);
    if (rst_now) begin
      m_lock = 1'b0; m_g = 0; m_rr = N - 1; m_pkt = 0; m_orph = '0; held = '0;
      for (int i = 0; i < N; i++) srcq[i].delete();
    end else begin
      for (int i = 0; i < N; i++)
        held[i] = bus.req_valid[i] && !orph_en[i] && !(e_xfer && m_g == i);
      if (e_xfer) begin
        void'(srcq[m_g].pop_front());
        if (e_tail) begin
          m_lock = 1'b0;
          m_pkt  = (m_pkt + 1) % 65536;
        end
      end
      if (e_arb) begin
        m_lock = 1'b1; m_g = e_win; m_rr = e_win;
      end
      m_orph = m_orph | e_oset;
    end
    #1;
    noc_rst = rst_req;
    rst_now = rst_req;
    for (int i = 0; i < N; i++) begin
      bit v;
      if (rst_req) v = 1'b0;
      else if (orph_en[i]) v = 1'b1;
      else v = (srcq[i].size() > 0) && (held[i] || ($urandom_range(99) < pv));
      bus.req_valid[i] = v;
      if (v && !orph_en[i]) begin
        bus.req_flit[i*DW +: DW] = srcq[i][0].d;
        bus.req_is_header[i]     = srcq[i][0].h;
        bus.req_is_tail[i]       = srcq[i][0].t;
      end else if (v) begin
        bus.req_flit[i*DW +: DW] = 32'hDEAD_0000 | i;
        bus.req_is_header[i]     = 1'b0;
        bus.req_is_tail[i]       = 1'b0;
      end else begin
        bus.req_flit[i*DW +: DW] = '0;
        bus.req_is_header[i]     = 1'b0;
        bus.req_is_tail[i]       = 1'b0;
      end
    end
    bus.out_ready = ($urandom_range(99) < pr);
    e_xfer = 1'b0; e_tail = 1'b0; e_arb = 1'b0; e_oset = '0;
    x_ov = 1'b0; x_flit = '0; x_rr = '0;
    if (!rst_req) begin
      if (m_lock) begin
        x_ov        = bus.req_valid[m_g];
        x_flit.d    = bus.req_flit[m_g*DW +: DW];
        x_flit.h    = bus.req_is_header[m_g];
        x_flit.t    = bus.req_is_tail[m_g];
        x_rr[m_g]   = bus.out_ready;
        e_xfer      = x_ov && bus.out_ready;
        e_tail      = e_xfer && x_flit.t;
        if (e_xfer) exp_q.push_back('{f: x_flit, g: m_g});
      end else begin
        for (int k = 1; k <= N; k++) begin
          int j = (m_rr + k) % N;
          if (!e_arb && bus.req_valid[j] && bus.req_is_header[j]) begin
            e_arb = 1'b1;
            e_win = j;
          end
        end
      end
      for (int i = 0; i < N; i++)
        e_oset[i] = bus.req_valid[i] && !bus.req_is_header[i] && !(m_lock && m_g == i);
    end
  endtask

  task automatic drain(input int pv, input int pr, input int budget);
    int n = 0;
    while (pending() && n < budget) begin
      step(pv, pr);
      n++;
    end
    chk("drain_budget", 64'(n < budget), 64'd1);
  endtask

  task automatic do_reset();
    rst_req = 1'b1;
    step(0, 0);
    step(0, 0);
    rst_req = 1'b0;
    step(0, 0);
  endtask

  always @(negedge noc_clk) begin
    exp_t e;
    if (mon_on) begin
      chk("out_valid", 64'(bus.out_valid), 64'(x_ov));
      chk("req_ready", 64'(bus.req_ready), 64'(x_rr));
      chk("out_flit", 64'({bus.out_flit, bus.out_is_header, bus.out_is_tail}), 64'(x_flit));
      chk("busy", 64'(bus.busy), 64'(m_lock));
      chk("grant_id", 64'(bus.grant_id), 64'(m_g));
      chk("pkt_sent", 64'(bus.pkt_sent), 64'(m_pkt));
      chk("err_orphan", 64'(bus.err_orphan), 64'(m_orph));
      if (bus.out_valid && bus.out_ready) begin
        xfer_cnt++;
        if (bus.out_is_header) hdr_log.push_back(int'(bus.grant_id));
        if (exp_q.size() == 0) chk("sb_unexpected_xfer", 64'd1, 64'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_flit", 64'({bus.out_flit, bus.out_is_header, bus.out_is_tail}), 64'(e.f));
          chk("sb_grant", 64'(bus.grant_id), 64'(e.g));
        end
      end
      chk("sb_missing_xfer", 64'(exp_q.size()), 64'd0);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0;
    int order2[5];
    order2 = '{0, 1, 2, 3, 0};
    bus.req_valid = '0; bus.req_flit = '0; bus.req_is_header = '0;
    bus.req_is_tail = '0; bus.out_ready = 1'b0;

    step(0, 0);
    mon_on = 1'b1;
    step(0, 0);
    rst_req = 1'b0;
    step(0, 0);
    #3;
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_grant", 64'(bus.grant_id), 64'd0);
    chk("rst_pkt", 64'(bus.pkt_sent), 64'd0);
    chk("rst_orphan", 64'(bus.err_orphan), 64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);

    // single source, 3-flit packet
    hdr_log.delete(); x0 = xfer_cnt;
    enqueue_pkt(1, 3);
    drain(100, 100, 50); #3;
    chk("s1_grant", 64'(bus.grant_id), 64'd1);
    chk("s1_pkt", 64'(bus.pkt_sent), 64'd1);
    chk("s1_xfers", 64'(xfer_cnt - x0), 64'd3);
    chk("s1_hdrs", 64'(hdr_log.size()), 64'd1);

    // all four contend with single-flit packets
    do_reset(); hdr_log.delete();
    enqueue_pkt(0, 1); enqueue_pkt(1, 1); enqueue_pkt(2, 1); enqueue_pkt(3, 1); enqueue_pkt(0, 1);
    drain(100, 100, 100); #3;
    chk("s2_pkt", 64'(bus.pkt_sent), 64'd5);
    chk("s2_hdrs", 64'(hdr_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < hdr_log.size(); k++)
      chk("s2_order", 64'(hdr_log[k]), 64'(order2[k]));

    // header arrives mid-lock
    hdr_log.delete();
    enqueue_pkt(0, 4);
    step(100, 100); step(100, 100);
    enqueue_pkt(2, 2);
    step(100, 100); #3;
    chk("s3_rdy2_stall", 64'(bus.req_ready[2]), 64'd0);
    chk("s3_grant_held", 64'(bus.grant_id), 64'd0);
    drain(100, 100, 50); #3;
    chk("s3_hdrs", 64'(hdr_log.size()), 64'd2);
    if (hdr_log.size() == 2) begin
      chk("s3_first", 64'(hdr_log[0]), 64'd0);
      chk("s3_second", 64'(hdr_log[1]), 64'd2);
    end

    // router back-pressure inside a lock
    enqueue_pkt(1, 3);
    step(100, 100); step(100, 100);
    repeat (10) begin
      step(100, 0); #3;
      chk("s4_ready_low", 64'(bus.req_ready[1]), 64'd0);
      chk("s4_flit_hold", 64'(bus.out_flit), 64'(srcq[1][0].d));
      chk("s4_pkt_hold", 64'(bus.pkt_sent), 64'd7);
    end
    drain(100, 100, 50); #3;
    chk("s4_pkt_after", 64'(bus.pkt_sent), 64'd8);

    // orphan body flit while idle
    do_reset();
    orph_en = 4'b1000;
    repeat (8) step(100, 100);
    #3;
    chk("s5_orphan", 64'(bus.err_orphan), 64'b1000);
    chk("s5_no_valid", 64'(bus.out_valid), 64'd0);
    chk("s5_not_busy", 64'(bus.busy), 64'd0);
    orph_en = '0;
    repeat (3) step(100, 100);
    #3;
    chk("s5_sticky", 64'(bus.err_orphan), 64'b1000);

    // reset mid-packet
    do_reset();
    enqueue_pkt(2, 4);
    step(100, 100); step(100, 100);
    rst_req = 1'b1;
    step(100, 100);
    rst_req = 1'b0;
    step(100, 100); #3;
    chk("s6_busy", 64'(bus.busy), 64'd0);
    chk("s6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("s6_pkt", 64'(bus.pkt_sent), 64'd0);
    hdr_log.delete();
    enqueue_pkt(2, 1); enqueue_pkt(0, 2);
    drain(100, 100, 50);
    chk("s6_hdrs", 64'(hdr_log.size()), 64'd2);
    if (hdr_log.size() == 2) begin
      chk("s6_first", 64'(hdr_log[0]), 64'd0);
      chk("s6_second", 64'(hdr_log[1]), 64'd2);
    end

    // random traffic
    do_reset();
    repeat (400) begin
      for (int r = 0; r < N; r++)
        if (srcq[r].size() < 3 && $urandom_range(9) == 0)
          enqueue_pkt(r, int'($urandom_range(4, 1)));
      step(60, 70);
    end
    drain(100, 100, 1000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
